// File: rtl/accum_alu_pkg.sv
// Shared opcode, FSM state and width definitions
// for the accumulator ALU.
package accum_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 3'd0,
    OP_LDA = 3'd1,
    OP_LDB = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_ADC = 3'd5,
    OP_MUL = 3'd6,
    OP_CLR = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/accum_alu_mul.sv
// Iterative shift-add multiplier, one partial
// product per cycle for WIDTH cycles.
module accum_alu_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] psum;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] addend;

  // product is the running sum including this
  // cycle's step, so it is final when last=1
  always_comb begin
    addend  = mplier[0] ? mcand : '0;
    product = psum + addend;
    last    = busy && (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      psum   <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      psum   <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      psum   <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/accum_alu_seq.sv
// Accumulator ALU with B-register file and
// a multi-cycle multiply.
module accum_alu_seq
  import accum_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OP_W-1:0]         cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_sel,
  input  logic [WIDTH-1:0]        cmd_data,
  output logic [WIDTH-1:0]        acc_out,
  output logic                    flag_c,
  output logic                    flag_z,
  output logic                    done
);

  state_e state_q;
  state_e state_d;
  op_e    op;

  logic [WIDTH-1:0]   breg [NREG];
  logic [WIDTH-1:0]   bsel;
  logic [WIDTH:0]     sum;
  logic               accept;
  logic               mul_start;
  logic               mul_busy;
  logic               mul_last;
  logic [2*WIDTH-1:0] mul_prod;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign bsel      = breg[cmd_sel];
  assign mul_start = accept && (op == OP_MUL)
                     && !mul_busy;

  always_comb begin
    sum = {1'b0, acc_out} + {1'b0, bsel};
    unique case (op)
      OP_ADC:  sum = {1'b0, acc_out}
                   + {1'b0, bsel}
                   + {{WIDTH{1'b0}}, flag_c};
      OP_SUB:  sum = {1'b0, acc_out}
                   + {1'b0, ~bsel}
                   + {{WIDTH{1'b0}}, 1'b1};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MUL;
      ST_MUL:  if (mul_last)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_out <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < NREG; i++)
        breg[i] <= '0;
    end else begin
      done <= 1'b0;
      if (mul_last) begin
        acc_out <= mul_prod[WIDTH-1:0];
        flag_c  <= |mul_prod[2*WIDTH-1:WIDTH];
        flag_z  <= (mul_prod[WIDTH-1:0] == '0);
        done    <= 1'b1;
      end else if (accept) begin
        done <= (op != OP_MUL);
        unique case (op)
          OP_LDA: begin
            acc_out <= cmd_data;
            flag_z  <= (cmd_data == '0);
          end
          OP_LDB: breg[cmd_sel] <= cmd_data;
          OP_ADD, OP_ADC, OP_SUB: begin
            acc_out <= sum[WIDTH-1:0];
            flag_c  <= sum[WIDTH];
            flag_z  <= (sum[WIDTH-1:0] == '0);
          end
          OP_CLR: begin
            acc_out <= '0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  accum_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (acc_out),
    .b       (bsel),
    .busy    (mul_busy),
    .last    (mul_last),
    .product (mul_prod)
  );

endmodule

// File: tb/tb_accum_alu_seq.sv
// Randomized self-checking bench for
// accum_alu_seq against an arithmetic model.
module tb_accum_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_sel = '0;
  logic [7:0] cmd_data = '0;
  logic [7:0] acc_out;
  logic       flag_c;
  logic       flag_z;
  logic       done;

  int checks = 0;
  int errors = 0;

  int m_acc, m_c, m_z;
  int m_b [4];

  always #5 clk = ~clk;

  accum_alu_seq #(.WIDTH(8), .NREG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_sel   (cmd_sel),
    .cmd_data  (cmd_data),
    .acc_out   (acc_out),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .done      (done)
  );

  function automatic void model_reset();
    m_acc = 0; m_c = 0; m_z = 0;
    for (int i = 0; i < 4; i++) m_b[i] = 0;
  endfunction

  function automatic void model_apply(int op, int sel, int data);
    int b, s;
    b = m_b[sel];
    case (op)
      1: begin m_acc = data; m_z = (data == 0); end
      2: m_b[sel] = data;
      3: begin
        s = m_acc + b;
        m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0);
      end
      4: begin
        m_c = (m_acc >= b); m_acc = (m_acc - b + 256) % 256;
        m_z = (m_acc == 0);
      end
      5: begin
        s = m_acc + b + m_c;
        m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0);
      end
      6: begin
        s = m_acc * b;
        m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0);
      end
      7: begin m_acc = 0; m_c = 0; m_z = 1; end
      default: ;
    endcase
  endfunction

  // Drives one command from a negedge and returns at the
  // negedge after completion; checks are left to callers.
  task automatic drive_op(input int op, input int sel,
                          input int data, input bit hold,
                          output int busy, output int dones,
                          output bit moved);
    int pre;
    pre = m_acc;
    cmd_op = op[2:0]; cmd_sel = sel[1:0];
    cmd_data = data[7:0]; cmd_valid = 1'b1;
    @(negedge clk);
    dones = int'(done); busy = 0; moved = 1'b0;
    while (!cmd_ready && busy < 20) begin
      busy++;
      if (acc_out !== pre[7:0]) moved = 1'b1;
      if (hold) cmd_op = 3'd7;
      else cmd_valid = 1'b0;
      @(negedge clk);
      dones += int'(done);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({acc_out, flag_c, flag_z} !== 10'h000) begin
      errors++;
      $display("FAIL reset_state got acc=%h c=%b z=%b want 00 0 0",
               acc_out, flag_c, flag_z);
    end
    checks++;
    if ({cmd_ready, done} !== 2'b10) begin
      errors++;
      $display("FAIL reset_hs got ready=%b done=%b want 1 0",
               cmd_ready, done);
    end
  endtask

  task automatic test_add();
    int ops [3] = '{1, 2, 3};
    int sels [3] = '{0, 1, 1};
    int dats [3] = '{5, 3, 0};
    int dones = 0, lows = 0;
    for (int i = 0; i < 3; i++) begin
      cmd_op = ops[i][2:0]; cmd_sel = sels[i][1:0];
      cmd_data = dats[i][7:0]; cmd_valid = 1'b1;
      @(negedge clk);
      if (!cmd_ready) lows++;
      dones += int'(done);
      model_apply(ops[i], sels[i], dats[i]);
    end
    cmd_valid = 1'b0;
    checks++;
    if ({acc_out, flag_c, flag_z} !== {8'h08, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_result got acc=%h c=%b z=%b want 08 0 0",
               acc_out, flag_c, flag_z);
    end
    checks++;
    if (dones !== 3 || lows !== 0) begin
      errors++;
      $display("FAIL add_hs got dones=%0d lows=%0d want 3 0",
               dones, lows);
    end
  endtask

  task automatic test_carry();
    int bz, dn; bit mv;
    drive_op(1, 0, 8'hFF, 0, bz, dn, mv); model_apply(1, 0, 8'hFF);
    drive_op(2, 0, 8'h01, 0, bz, dn, mv); model_apply(2, 0, 8'h01);
    drive_op(3, 0, 0, 0, bz, dn, mv);     model_apply(3, 0, 0);
    checks++;
    if ({acc_out, flag_c, flag_z} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL add_wrap got acc=%h c=%b z=%b want 00 1 1",
               acc_out, flag_c, flag_z);
    end
    drive_op(5, 0, 0, 0, bz, dn, mv);     model_apply(5, 0, 0);
    checks++;
    if ({acc_out, flag_c, flag_z} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL adc got acc=%h c=%b z=%b want 02 0 0",
               acc_out, flag_c, flag_z);
    end
  endtask

  task automatic test_sub();
    int bz, dn; bit mv;
    drive_op(1, 0, 3, 0, bz, dn, mv); model_apply(1, 0, 3);
    drive_op(2, 1, 5, 0, bz, dn, mv); model_apply(2, 1, 5);
    drive_op(4, 1, 0, 0, bz, dn, mv); model_apply(4, 1, 0);
    checks++;
    if ({acc_out, flag_c} !== {8'hFE, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow got acc=%h c=%b want fe 0",
               acc_out, flag_c);
    end
    drive_op(1, 0, 5, 0, bz, dn, mv); model_apply(1, 0, 5);
    drive_op(4, 1, 0, 0, bz, dn, mv); model_apply(4, 1, 0);
    checks++;
    if ({acc_out, flag_c, flag_z} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_equal got acc=%h c=%b z=%b want 00 1 1",
               acc_out, flag_c, flag_z);
    end
  endtask

  task automatic test_mul();
    int bz, dn; bit mv;
    drive_op(1, 0, 8'h12, 0, bz, dn, mv); model_apply(1, 0, 8'h12);
    drive_op(2, 2, 8'h10, 0, bz, dn, mv); model_apply(2, 2, 8'h10);
    drive_op(6, 2, 0, 1, bz, dn, mv);     model_apply(6, 2, 0);
    checks++;
    if (bz !== 8 || dn !== 1 || mv !== 1'b0) begin
      errors++;
      $display("FAIL mul_timing got busy=%0d dones=%0d moved=%b want 8 1 0",
               bz, dn, mv);
    end
    checks++;
    if ({acc_out, flag_c, flag_z} !== {8'h20, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mul_result got acc=%h c=%b z=%b want 20 1 0",
               acc_out, flag_c, flag_z);
    end
  endtask

  task automatic test_mul_abort();
    int bz, dn; bit mv;
    int late = 0;
    drive_op(1, 0, 8'h12, 0, bz, dn, mv);
    drive_op(2, 2, 8'h10, 0, bz, dn, mv);
    cmd_op = 3'd6; cmd_sel = 2'd2; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({acc_out, cmd_ready, done} !== {8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mul_abort got acc=%h ready=%b done=%b want 00 1 0",
               acc_out, cmd_ready, done);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      late += int'(done);
    end
    checks++;
    if (late !== 0) begin
      errors++;
      $display("FAIL mul_abort_late got dones=%0d want 0", late);
    end
  endtask

  task automatic test_random();
    int bz, dn, op, sel, dat; bit mv, hold;
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 3));
      dat = int'($urandom_range(0, 255));
      hold = 1'($urandom_range(0, 1));
      drive_op(op, sel, dat, hold, bz, dn, mv);
      model_apply(op, sel, dat);
      checks++;
      if ({acc_out, flag_c, flag_z} !==
          {8'(m_acc), 1'(m_c), 1'(m_z)}) begin
        errors++;
        $display("FAIL rand_state op=%0d got acc=%h c=%b z=%b want %h %0d %0d",
                 op, acc_out, flag_c, flag_z, m_acc, m_c, m_z);
      end
      checks++;
      if (dn !== 1 || bz !== ((op == 6) ? 8 : 0) || mv !== 1'b0) begin
        errors++;
        $display("FAIL rand_hs op=%0d got dones=%0d busy=%0d moved=%b",
                 op, dn, bz, mv);
      end
    end
  endtask

  task automatic test_back_to_back();
    int op, sel, dat;
    int bad = 0;
    for (int n = 0; n < 40; n++) begin
      do op = int'($urandom_range(0, 7)); while (op == 6);
      sel = int'($urandom_range(0, 3));
      dat = int'($urandom_range(0, 255));
      cmd_op = op[2:0]; cmd_sel = sel[1:0];
      cmd_data = dat[7:0]; cmd_valid = 1'b1;
      @(negedge clk);
      model_apply(op, sel, dat);
      if ({done, cmd_ready, acc_out, flag_c, flag_z} !==
          {2'b11, 8'(m_acc), 1'(m_c), 1'(m_z)}) begin
        bad++;
        $display("FAIL b2b step=%0d op=%0d got acc=%h c=%b z=%b done=%b want %h %0d %0d 1",
                 n, op, acc_out, flag_c, flag_z, done, m_acc, m_c, m_z);
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_total got %0d bad steps want 0", bad);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_add();
    test_carry();
    test_sub();
    test_mul();
    test_mul_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
